// File: rtl/chime_scheduler.sv
// chime_scheduler: hourly chime initiator.
// Detects the rising edge of the top-of-hour condition (or a test request)
// and opens an enable window long enough for the hour's beep count plus a
// guard period. After the window it holds enable low for at least one beat
// period so the downstream sequencer can re-arm.
// Optional feature macro: CHIME_QUIET_HOURS_EN (silences top-of-hour chimes
// inside the QUIET_START..QUIET_END-1 window; test_req still chimes).
module chime_scheduler #(
  parameter bit HOUR12      = 1'b1,
  parameter int GUARD_BEATS = 2,
  parameter int QUIET_START = 22,
  parameter int QUIET_END   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic       chime_on,
  input  logic       set_mode,
  input  logic       test_req,
  input  logic       beat,
  output logic [4:0] count,
  output logic       enable,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    COOL = 2'd2
  } state_t;

  // Reject parameter values the window arithmetic cannot hold.
  if (GUARD_BEATS < 1 || GUARD_BEATS > 7) begin : g_bad_guard
    $error("GUARD_BEATS must be in 1..7");
  end
  if (QUIET_START < 0 || QUIET_START > 23 || QUIET_END < 0 || QUIET_END > 23) begin : g_bad_quiet
    $error("QUIET_START and QUIET_END must be in 0..23");
  end

  localparam logic [7:0] GUARD = 8'(GUARD_BEATS);

  state_t     state;
  state_t     state_next;
  logic       toh;
  logic       toh_d;
  logic       toh_edge;
  logic       toh_ok;
  logic       trig;
  logic       load;
  logic       beat_inc;
  logic [4:0] mapped;
  logic [7:0] beat_cnt;
  logic [7:0] last_beat;

  // Map the 24-hour clock value onto the number of beeps to sound.
  function automatic logic [4:0] map_hour(input logic [4:0] h);
    if (h == 5'd0) return HOUR12 ? 5'd12 : 5'd24;
    if (HOUR12 && h > 5'd12) return h - 5'd12;
    return h;
  endfunction

  assign toh      = (minute == 6'd0) && (second == 6'd0);
  assign toh_edge = toh & ~toh_d;
  assign mapped   = map_hour(hour);
  // Index of the final beat in the window; count+guard never exceeds 31.
  assign last_beat = {3'b000, count} + GUARD - 8'd1;

`ifdef CHIME_QUIET_HOURS_EN
  localparam logic [4:0] QS = 5'(QUIET_START);
  localparam logic [4:0] QE = 5'(QUIET_END);
  logic quiet;

  // Quiet window membership; wraps through midnight when start > end.
  always_comb begin
    quiet = 1'b0;
    if (QS < QE)      quiet = (hour >= QS) && (hour < QE);
    else if (QS > QE) quiet = (hour >= QS) || (hour < QE);
  end

  assign toh_ok = toh_edge & ~quiet;
`else
  assign toh_ok = toh_edge;
`endif

  // The manual test request is never subject to the quiet window.
  assign trig = toh_ok | test_req;

  // Next-state and datapath control for the chime window.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and synthesis cannot infer a latch.
    state_next = state;
    load       = 1'b0;
    beat_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (trig && chime_on && !set_mode && hour <= 5'd23) begin
          state_next = PLAY;
          load       = 1'b1;
        end
      end
      PLAY: begin
        if (!chime_on || set_mode) begin
          state_next = COOL;
        end else if (beat) begin
          if (beat_cnt == last_beat) state_next = COOL;
          else                       beat_inc   = 1'b1;
        end
      end
      COOL: begin
        if (beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, latched count, beat counter and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state    <= IDLE;
      toh_d    <= 1'b1;
      count    <= 5'd0;
      beat_cnt <= 8'd0;
      enable   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state  <= state_next;
      toh_d  <= toh;
      enable <= (state_next == PLAY);
      busy   <= (state_next != IDLE);
      if (load) begin
        count    <= mapped;
        beat_cnt <= 8'd0;
      end else if (beat_inc) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/chime_scheduler.md
# chime_scheduler

Hourly chime initiator for the FPGA clock. Watches the running time-of-day, detects the top of each hour, and drives a beep count plus an enable level into the beep-sequencer downstream. Holds enable for exactly the chime window, then drops it so the sequencer re-arms. Sits between the time counter and the buzzer path.

## Interface
- `HOUR12`, 1: 1 = chime 1..12 (12-hour); 0 = chime 1..24 (hour 0 chimes 24)
- `GUARD_BEATS`, 2: extra beat periods enable stays high after the last expected beep (1..7)
- `QUIET_START`, 22: first silent hour (only with CHIME_QUIET_HOURS_EN)
- `QUIET_END`, 7: first non-silent hour after the quiet window (only with CHIME_QUIET_HOURS_EN)

Ports:
- `clk` in 1: system clock
- `rst` in 1: synchronous reset, active-high
- `hour` in 5: current hour, 0..23
- `minute` in 6: current minute, 0..59
- `second` in 6: current second, 0..59
- `chime_on` in 1: user switch; 0 blocks and aborts chimes
- `set_mode` in 1: time being edited; 1 blocks and aborts chimes
- `test_req` in 1: one-cycle pulse; chime current hour immediately
- `beat` in 1: one-cycle strobe, one per beep period from the buzzer path
- `count` out 5: beep count for the sequencer
- `enable` out 1: chime window active
- `busy` out 1: high in any state other than IDLE

## Operation
- Top-of-hour condition `toh = (minute==0 && second==0)`; registered copy `toh_d`. Trigger = `toh & ~toh_d` (rising edge only). Holding time at xx:00:00 yields one trigger.
- Trigger sources: toh edge or `test_req`. Accepted only in IDLE with `chime_on=1`, `set_mode=0`, `hour<=23`; otherwise dropped without queuing.
- Count mapping: HOUR12=1: 0→12, 1..12→same, 13..23→hour−12. HOUR12=0: 0→24, 1..23→same.
- States:
  - IDLE: enable=0. Valid trigger → latch mapped count, clear beat_cnt → PLAY.
  - PLAY: enable=1. Each `beat` increments beat_cnt (5-bit + 3-bit guard, no wrap: window max 31). On the beat where beat_cnt == count+GUARD_BEATS−1 → COOL. `chime_on=0` or `set_mode=1` → COOL immediately (abort).
  - COOL: enable=0; wait for one `beat` → IDLE. Guarantees enable low for at least one full beat period.
- `count` holds latched value from IDLE→PLAY until the next accepted trigger; it is not cleared on return to IDLE.
- Trigger in PLAY/COOL (including `test_req`): ignored.

## Timing
- Reset values: count=0, enable=0, busy=0, state=IDLE, beat_cnt=0, `toh_d=1` (reset during xx:00:00 does not chime).
- Trigger sampled in cycle N → count valid and enable=1 from cycle N+1.
- Window: enable high from N+1 through the cycle of the (count+GUARD_BEATS)th beat; low from the following cycle.
- Abort: `chime_on` falls or `set_mode` rises in cycle M → enable=0 from M+1.
- `beat` in the same cycle as the transition into PLAY is not counted.
- `rst` mid-chime: all outputs to reset values next cycle; no chime resumes.
- `busy` = registered, changes in the same cycle as state.

## Configuration
- `CHIME_QUIET_HOURS_EN` defined: triggers with hour in the quiet window are dropped. Window wraps when QUIET_START > QUIET_END (defaults: 22..23, 0..6 silent). QUIET_START == QUIET_END means no quiet hours. `test_req` bypasses the quiet check.
- Not defined: no quiet-window logic; QUIET_START/QUIET_END unused; every valid trigger chimes.

## Test plan
- hour=15, minute 59→0 with second=0, GUARD_BEATS=2, HOUR12=1 → enable high next cycle, count=3, low after 5th beat, busy low one beat later.
- hour=0, HOUR12=0, toh edge → count=24; HOUR12=1 → count=12; time held at 00:00:00 for 200 cycles → exactly one chime.
- Mid-PLAY `set_mode=1` in cycle M → enable=0 at M+1, state COOL, IDLE after next beat; `test_req` during COOL → ignored.
- `rst` asserted while minute=0, second=0 then released → no chime; `rst` during PLAY → enable=0, count=0, busy=0 next cycle.
- With CHIME_QUIET_HOURS_EN, hour=23 and hour=3 toh edges → no enable; hour=7 → chime count=7; `test_req` at hour=23 → chime count=11.
- `chime_on=0` at toh edge → no chime; `chime_on` set 1 later within the same second → still no chime (edge consumed).
